// File: rtl/mem_sequencer.sv
// Load/store sequencer: turns a decoded LW/SW into a single RAM transaction,
// stalls the front end while it is outstanding, and writes LW data back.
module mem_sequencer #(
  parameter int DATA_SIZE   = 32,
  parameter int ADDR_SIZE   = 16,
  parameter int R_ADDR_SIZE = 5,
  parameter int TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   ram_enable_read,
  input  logic                   ram_enable_write,
  input  logic [ADDR_SIZE-1:0]   address,
  input  logic [DATA_SIZE-1:0]   write_data,
  input  logic [R_ADDR_SIZE-1:0] destination,
  output logic                   stall,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_SIZE-1:0]   mem_addr,
  output logic [DATA_SIZE-1:0]   mem_wdata,
  input  logic                   mem_ack,
  input  logic [DATA_SIZE-1:0]   mem_rdata,
  output logic                   wb_valid,
  output logic [R_ADDR_SIZE-1:0] wb_dest,
  output logic [DATA_SIZE-1:0]   wb_data,
  output logic                   error
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]             state;
  logic [7:0]             wait_cnt;
  logic [R_ADDR_SIZE-1:0] dest_q;
  logic                   issue;
  logic                   conflict;

  assign issue    = (state == IDLE) && (ram_enable_read ^ ram_enable_write);
  assign conflict = (state == IDLE) && ram_enable_read && ram_enable_write;

  // Gated by reset so stall is low the instant reset asserts, even with enables high.
  assign stall = reset_L && (issue || (state == BUSY) || (state == WB));

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      dest_q    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_dest   <= '0;
      wb_data   <= '0;
      error     <= 1'b0;
    end else begin
      error    <= 1'b0;
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            mem_addr  <= address;
            mem_wdata <= write_data;
            dest_q    <= destination;
            mem_we    <= ram_enable_write;
            mem_req   <= 1'b1;
            wait_cnt  <= 8'd0;
            state     <= BUSY;
          end else if (conflict) begin
            error <= 1'b1;
          end
        end
        BUSY: begin
          // An ack on the last allowed cycle wins over the timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (mem_we) begin
              state <= IDLE;
            end else begin
              wb_data  <= mem_rdata;
              wb_dest  <= dest_q;
              wb_valid <= 1'b1;
              state    <= WB;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            error   <= 1'b1;
            state   <= IDLE;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WB: begin
          state <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: LW/SW transactions, timeout, illegal
// request, reset during an access and back-to-back issue timing.
module tb_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset_L;
  logic        ram_enable_read;
  logic        ram_enable_write;
  logic [15:0] address;
  logic [31:0] write_data;
  logic [4:0]  destination;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_sequencer #(
    .DATA_SIZE(32), .ADDR_SIZE(16), .R_ADDR_SIZE(5), .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset_L(reset_L),
    .ram_enable_read(ram_enable_read),
    .ram_enable_write(ram_enable_write),
    .address(address),
    .write_data(write_data),
    .destination(destination),
    .stall(stall),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .wb_valid(wb_valid),
    .wb_dest(wb_dest),
    .wb_data(wb_data),
    .error(error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_L = 1'b0;
    ram_enable_read = 1'b0;
    ram_enable_write = 1'b0;
    address = '0;
    write_data = '0;
    destination = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;

    // Reset state
    step();
    step();
    check("rst_stall", stall, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_dest", wb_dest, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_error", error, 0);
    reset_L = 1'b1;

    // LW, ack on first BUSY cycle; issued on first edge after reset release
    ram_enable_read = 1'b1; address = 16'h0010; destination = 5'd7;
    #1 check("lw_issue_stall", stall, 1);
    step();
    ram_enable_read = 1'b0;
    check("lw_busy_req", mem_req, 1);
    check("lw_busy_we", mem_we, 0);
    check("lw_busy_addr", mem_addr, 16'h0010);
    check("lw_busy_stall", stall, 1);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    check("lw_wb_req", mem_req, 0);
    check("lw_wb_valid", wb_valid, 1);
    check("lw_wb_dest", wb_dest, 7);
    check("lw_wb_data", wb_data, 32'hDEADBEEF);
    check("lw_wb_stall", stall, 1);
    step();
    check("lw_idle_valid", wb_valid, 0);
    check("lw_idle_stall", stall, 0);
    check("lw_hold_data", wb_data, 32'hDEADBEEF);
    check("lw_hold_dest", wb_dest, 7);

    // SW, ack after 3 wait cycles
    ram_enable_write = 1'b1; address = 16'h0004; write_data = 32'h12345678;
    step();
    ram_enable_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sw_wait_req", mem_req, 1);
      check("sw_wait_we", mem_we, 1);
      check("sw_wait_wdata", mem_wdata, 32'h12345678);
      step();
    end
    check("sw_ack_req", mem_req, 1);
    check("sw_ack_addr", mem_addr, 16'h0004);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("sw_done_req", mem_req, 0);
    check("sw_done_valid", wb_valid, 0);
    check("sw_done_error", error, 0);
    check("sw_done_stall", stall, 0);

    // LW timeout: mem_req exactly 15 cycles then one error pulse
    ram_enable_read = 1'b1; address = 16'h0100; destination = 5'd3;
    step();
    ram_enable_read = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("to_req", mem_req, 1);
      check("to_err_low", error, 0);
      step();
    end
    check("to_req_drop", mem_req, 0);
    check("to_error", error, 1);
    check("to_no_wb", wb_valid, 0);
    check("to_stall", stall, 0);
    step();
    check("to_error_once", error, 0);

    // LW with ack on the 15th BUSY cycle completes normally
    ram_enable_read = 1'b1; address = 16'h0200; destination = 5'd12;
    step();
    ram_enable_read = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check("to15_req", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_5A5A;
    step();
    mem_ack = 1'b0;
    check("to15_valid", wb_valid, 1);
    check("to15_error", error, 0);
    check("to15_data", wb_data, 32'hA5A5_5A5A);
    check("to15_dest", wb_dest, 12);
    step();
    check("to15_idle_valid", wb_valid, 0);
    check("to15_idle_error", error, 0);

    // Both enables high in IDLE
    ram_enable_read = 1'b1; ram_enable_write = 1'b1;
    #1 check("both_stall_comb", stall, 0);
    step();
    check("both_req", mem_req, 0);
    check("both_error", error, 1);
    check("both_stall", stall, 0);
    ram_enable_read = 1'b0; ram_enable_write = 1'b0;
    step();
    check("both_error_once", error, 0);
    check("both_req_after", mem_req, 0);

    // Reset in 2nd BUSY cycle of an LW
    ram_enable_read = 1'b1; address = 16'h0020; destination = 5'd9;
    step();
    ram_enable_read = 1'b0;
    step();
    check("rb_req_before", mem_req, 1);
    reset_L = 1'b0;
    #1;
    check("rb_req_async", mem_req, 0);
    check("rb_stall_async", stall, 0);
    step();
    reset_L = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    step();
    mem_ack = 1'b0;
    check("rb_late_valid", wb_valid, 0);
    check("rb_late_error", error, 0);
    check("rb_late_req", mem_req, 0);
    step();
    check("rb_late_valid2", wb_valid, 0);
    ram_enable_write = 1'b1; address = 16'h0008; write_data = 32'hCAFEF00D;
    step();
    ram_enable_write = 1'b0;
    check("rb_sw_req", mem_req, 1);
    check("rb_sw_we", mem_we, 1);
    check("rb_sw_wdata", mem_wdata, 32'hCAFEF00D);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("rb_sw_done", mem_req, 0);
    check("rb_sw_error", error, 0);

    // Back-to-back LW then SW with inputs changing during BUSY
    ram_enable_read = 1'b1; address = 16'h0030; destination = 5'd5; write_data = 32'h0;
    step();
    ram_enable_read = 1'b1; ram_enable_write = 1'b1;
    address = 16'hFFFF; destination = 5'd1; write_data = 32'hFFFF_FFFF;
    check("bb_lw_addr", mem_addr, 16'h0030);
    check("bb_lw_we", mem_we, 0);
    step();
    check("bb_lw_addr_hold", mem_addr, 16'h0030);
    check("bb_lw_wdata_hold", mem_wdata, 32'h0);
    check("bb_lw_err", error, 0);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    mem_ack = 1'b0;
    ram_enable_read = 1'b0; ram_enable_write = 1'b1;
    address = 16'h0040; write_data = 32'h0000_0055;
    check("bb_wb_valid", wb_valid, 1);
    check("bb_wb_dest", wb_dest, 5);
    check("bb_wb_data", wb_data, 32'h1111_2222);
    step();
    check("bb_m2_req", mem_req, 0);
    check("bb_m2_stall", stall, 1);
    check("bb_m2_valid", wb_valid, 0);
    step();
    ram_enable_write = 1'b0; address = 16'h0099; write_data = 32'h0;
    check("bb_sw_req", mem_req, 1);
    check("bb_sw_we", mem_we, 1);
    check("bb_sw_addr", mem_addr, 16'h0040);
    check("bb_sw_wdata", mem_wdata, 32'h0000_0055);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("bb_sw_done", mem_req, 0);
    check("bb_sw_valid", wb_valid, 0);
    check("bb_sw_error", error, 0);
    check("bb_sw_stall", stall, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
